// File: rtl/hsid_x_ctrl_reg_pkg.sv
// Register map, write permissions and run-FSM encoding of the HSID-X control block.
package hsid_x_ctrl_reg_pkg;

  import hsid_x_reg_pkg::*;

  localparam int unsigned BlockAw          = HSID_ADDR_WIDTH;
  localparam int unsigned HSID_X_REF_WIDTH = 16;
  localparam int unsigned HSID_X_NUM_REGS  = 9;

  typedef enum logic [3:0] {
    HSID_X_CTRL_STATUS              = 4'd0,
    HSID_X_CTRL_LIBRARY_SIZE        = 4'd1,
    HSID_X_CTRL_PIXEL_BANDS         = 4'd2,
    HSID_X_CTRL_CAPTURED_PIXEL_ADDR = 4'd3,
    HSID_X_CTRL_LIBRARY_PIXEL_ADDR  = 4'd4,
    HSID_X_CTRL_MSE_MIN_REF         = 4'd5,
    HSID_X_CTRL_MSE_MAX_REF         = 4'd6,
    HSID_X_CTRL_MSE_MIN_VALUE       = 4'd7,
    HSID_X_CTRL_MSE_MAX_VALUE       = 4'd8
  } hsid_x_ctrl_id_e;

  localparam logic [BlockAw-1:0] HSID_X_CTRL_STATUS_OFFSET              = 6'h00;
  localparam logic [BlockAw-1:0] HSID_X_CTRL_LIBRARY_SIZE_OFFSET        = 6'h04;
  localparam logic [BlockAw-1:0] HSID_X_CTRL_PIXEL_BANDS_OFFSET         = 6'h08;
  localparam logic [BlockAw-1:0] HSID_X_CTRL_CAPTURED_PIXEL_ADDR_OFFSET = 6'h0C;
  localparam logic [BlockAw-1:0] HSID_X_CTRL_LIBRARY_PIXEL_ADDR_OFFSET  = 6'h10;
  localparam logic [BlockAw-1:0] HSID_X_CTRL_MSE_MIN_REF_OFFSET         = 6'h14;
  localparam logic [BlockAw-1:0] HSID_X_CTRL_MSE_MAX_REF_OFFSET         = 6'h18;
  localparam logic [BlockAw-1:0] HSID_X_CTRL_MSE_MIN_VALUE_OFFSET       = 6'h1C;
  localparam logic [BlockAw-1:0] HSID_X_CTRL_MSE_MAX_VALUE_OFFSET       = 6'h20;

  // Byte lanes each register accepts; MSE results are read-only.
  localparam logic [HSID_STRB_WIDTH-1:0] HSID_X_CTRL_PERMIT [HSID_X_NUM_REGS] = '{
    4'b0001,
    4'b1111, 4'b1111, 4'b1111, 4'b1111,
    4'b0000, 4'b0000, 4'b0000, 4'b0000
  };

  localparam int unsigned STATUS_START_BIT = 0;
  localparam int unsigned STATUS_CLEAR_BIT = 1;
  localparam int unsigned STATUS_IDLE_BIT  = 2;
  localparam int unsigned STATUS_BUSY_BIT  = 3;
  localparam int unsigned STATUS_DONE_BIT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } hsid_x_ctrl_state_e;

  function automatic logic [HSID_WORD_WIDTH-1:0] apply_strb(
    input logic [HSID_WORD_WIDTH-1:0] old_val,
    input logic [HSID_WORD_WIDTH-1:0] new_val,
    input logic [HSID_STRB_WIDTH-1:0] strb
  );
    logic [HSID_WORD_WIDTH-1:0] res;
    res = old_val;
    for (int unsigned b = 0; b < HSID_STRB_WIDTH; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hsid_x_reg_pkg.sv
// Generic HSID-X register bus payloads shared by every register block.
package hsid_x_reg_pkg;

  localparam int unsigned HSID_WORD_WIDTH = 32;
  localparam int unsigned HSID_ADDR_WIDTH = 6;
  localparam int unsigned HSID_STRB_WIDTH = HSID_WORD_WIDTH / 8;

  typedef struct packed {
    logic                       valid;
    logic                       write;
    logic [HSID_ADDR_WIDTH-1:0] addr;
    logic [HSID_WORD_WIDTH-1:0] wdata;
    logic [HSID_STRB_WIDTH-1:0] wstrb;
  } reg_req_t;

  typedef struct packed {
    logic [HSID_WORD_WIDTH-1:0] rdata;
    logic                       error;
    logic                       ready;
  } reg_rsp_t;

endpackage

// File: rtl/hsid_x_ctrl_fsm.sv
// Run-control FSM: IDLE/BUSY/DONE sequencing, start/clear pulses and the done interrupt.
module hsid_x_ctrl_fsm
  import hsid_x_ctrl_reg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_req,
  input  logic               clear_req,
  input  logic               hw_done,
  output hsid_x_ctrl_state_e state,
  output logic               start_pulse,
  output logic               clear_pulse,
  output logic               irq,
  output logic               capture_c,
  output logic               zero_c
);

  hsid_x_ctrl_state_e state_q, state_d;
  logic start_q, start_d;
  logic clear_q, clear_d;
  logic irq_q, irq_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      clear_q <= clear_d;
      irq_q   <= irq_d;
    end
  end

  // Clear overrides everything, including a simultaneous start or hw_done.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    clear_d   = 1'b0;
    capture_c = 1'b0;
    zero_c    = 1'b0;
    if (clear_req) begin
      state_d = ST_IDLE;
      clear_d = 1'b1;
      zero_c  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            state_d = ST_BUSY;
            start_d = 1'b1;
          end
        end
        ST_BUSY: begin
          if (hw_done) begin
            state_d   = ST_DONE;
            capture_c = 1'b1;
          end
        end
        ST_DONE: begin
          if (start_req) begin
            state_d = ST_BUSY;
            start_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    irq_d = (state_d == ST_DONE);
  end

  assign state       = state_q;
  assign start_pulse = start_q;
  assign clear_pulse = clear_q;
  assign irq         = irq_q;

endmodule

// File: rtl/hsid_x_ctrl_reg_resp.sv
// HSID-X control register responder: address decode, config/MSE registers and bus response.
module hsid_x_ctrl_reg_resp
  import hsid_x_reg_pkg::*;
  import hsid_x_ctrl_reg_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = HSID_WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = BlockAw,
  parameter int unsigned REF_WIDTH  = HSID_X_REF_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  reg_req_t              reg_req_i,
  output reg_rsp_t              reg_rsp_o,
  input  logic                  hw_done_i,
  input  logic [REF_WIDTH-1:0]  mse_min_ref_i,
  input  logic [REF_WIDTH-1:0]  mse_max_ref_i,
  input  logic [WORD_WIDTH-1:0] mse_min_value_i,
  input  logic [WORD_WIDTH-1:0] mse_max_value_i,
  output logic [WORD_WIDTH-1:0] library_size_o,
  output logic [WORD_WIDTH-1:0] pixel_bands_o,
  output logic [WORD_WIDTH-1:0] captured_pixel_addr_o,
  output logic [WORD_WIDTH-1:0] library_pixel_addr_o,
  output logic                  start_o,
  output logic                  clear_o,
  output logic                  irq_o
);

  logic [ADDR_WIDTH-1:0]      offset;
  hsid_x_ctrl_id_e            id;
  logic                       hit;
  logic [HSID_STRB_WIDTH-1:0] permit;
  logic                       strb_ok;
  logic                       wr_legal;
  logic                       wr_en;
  logic                       status_wr;
  logic                       start_in_busy;
  logic                       start_req;
  logic                       clear_req;

  hsid_x_ctrl_state_e         state;
  logic                       capture;
  logic                       zero;

  logic [WORD_WIDTH-1:0] library_size_q;
  logic [WORD_WIDTH-1:0] pixel_bands_q;
  logic [WORD_WIDTH-1:0] captured_pixel_addr_q;
  logic [WORD_WIDTH-1:0] library_pixel_addr_q;
  logic [WORD_WIDTH-1:0] mse_min_ref_q;
  logic [WORD_WIDTH-1:0] mse_max_ref_q;
  logic [WORD_WIDTH-1:0] mse_min_value_q;
  logic [WORD_WIDTH-1:0] mse_max_value_q;

  logic [WORD_WIDTH-1:0] status_word;
  logic [WORD_WIDTH-1:0] rdata_mux;
  reg_rsp_t              rsp;

  assign offset = ADDR_WIDTH'(reg_req_i.addr);

  // Only exact word offsets hit; anything else (including misaligned) is unmapped.
  always_comb begin
    hit = 1'b1;
    id  = HSID_X_CTRL_STATUS;
    case (offset)
      HSID_X_CTRL_STATUS_OFFSET:              id = HSID_X_CTRL_STATUS;
      HSID_X_CTRL_LIBRARY_SIZE_OFFSET:        id = HSID_X_CTRL_LIBRARY_SIZE;
      HSID_X_CTRL_PIXEL_BANDS_OFFSET:         id = HSID_X_CTRL_PIXEL_BANDS;
      HSID_X_CTRL_CAPTURED_PIXEL_ADDR_OFFSET: id = HSID_X_CTRL_CAPTURED_PIXEL_ADDR;
      HSID_X_CTRL_LIBRARY_PIXEL_ADDR_OFFSET:  id = HSID_X_CTRL_LIBRARY_PIXEL_ADDR;
      HSID_X_CTRL_MSE_MIN_REF_OFFSET:         id = HSID_X_CTRL_MSE_MIN_REF;
      HSID_X_CTRL_MSE_MAX_REF_OFFSET:         id = HSID_X_CTRL_MSE_MAX_REF;
      HSID_X_CTRL_MSE_MIN_VALUE_OFFSET:       id = HSID_X_CTRL_MSE_MIN_VALUE;
      HSID_X_CTRL_MSE_MAX_VALUE_OFFSET:       id = HSID_X_CTRL_MSE_MAX_VALUE;
      default:                                hit = 1'b0;
    endcase
  end

  assign permit  = hit ? HSID_X_CTRL_PERMIT[id] : '0;
  assign strb_ok = (|reg_req_i.wstrb) && ~|(reg_req_i.wstrb & ~permit);

  // A lone START while already running is rejected; START+CLEAR is a plain clear.
  assign status_wr     = reg_req_i.valid && reg_req_i.write && hit && strb_ok &&
                         (id == HSID_X_CTRL_STATUS);
  assign start_in_busy = status_wr && reg_req_i.wdata[STATUS_START_BIT] &&
                         !reg_req_i.wdata[STATUS_CLEAR_BIT] && (state == ST_BUSY);
  assign wr_legal      = strb_ok && !start_in_busy;
  assign wr_en         = reg_req_i.valid && reg_req_i.write && hit && wr_legal;
  assign clear_req     = wr_en && (id == HSID_X_CTRL_STATUS) &&
                         reg_req_i.wdata[STATUS_CLEAR_BIT];
  assign start_req     = wr_en && (id == HSID_X_CTRL_STATUS) &&
                         reg_req_i.wdata[STATUS_START_BIT];

  hsid_x_ctrl_fsm u_fsm (
    .clk         (clk_i),
    .rst         (rst_i),
    .start_req   (start_req),
    .clear_req   (clear_req),
    .hw_done     (hw_done_i),
    .state       (state),
    .start_pulse (start_o),
    .clear_pulse (clear_o),
    .irq         (irq_o),
    .capture_c   (capture),
    .zero_c      (zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      library_size_q        <= '0;
      pixel_bands_q         <= '0;
      captured_pixel_addr_q <= '0;
      library_pixel_addr_q  <= '0;
    end else if (wr_en) begin
      case (id)
        HSID_X_CTRL_LIBRARY_SIZE:
          library_size_q <= apply_strb(library_size_q, reg_req_i.wdata, reg_req_i.wstrb);
        HSID_X_CTRL_PIXEL_BANDS:
          pixel_bands_q <= apply_strb(pixel_bands_q, reg_req_i.wdata, reg_req_i.wstrb);
        HSID_X_CTRL_CAPTURED_PIXEL_ADDR:
          captured_pixel_addr_q <= apply_strb(captured_pixel_addr_q, reg_req_i.wdata,
                                              reg_req_i.wstrb);
        HSID_X_CTRL_LIBRARY_PIXEL_ADDR:
          library_pixel_addr_q <= apply_strb(library_pixel_addr_q, reg_req_i.wdata,
                                             reg_req_i.wstrb);
        default: ;
      endcase
    end
  end

  // Results latch on the done edge and persist until the next sweep or a clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mse_min_ref_q   <= '0;
      mse_max_ref_q   <= '0;
      mse_min_value_q <= '0;
      mse_max_value_q <= '0;
    end else if (zero) begin
      mse_min_ref_q   <= '0;
      mse_max_ref_q   <= '0;
      mse_min_value_q <= '0;
      mse_max_value_q <= '0;
    end else if (capture) begin
      mse_min_ref_q   <= WORD_WIDTH'(mse_min_ref_i);
      mse_max_ref_q   <= WORD_WIDTH'(mse_max_ref_i);
      mse_min_value_q <= mse_min_value_i;
      mse_max_value_q <= mse_max_value_i;
    end
  end

  always_comb begin
    status_word                  = '0;
    status_word[STATUS_IDLE_BIT] = (state == ST_IDLE);
    status_word[STATUS_BUSY_BIT] = (state == ST_BUSY);
    status_word[STATUS_DONE_BIT] = (state == ST_DONE);
  end

  always_comb begin
    rdata_mux = '0;
    case (id)
      HSID_X_CTRL_STATUS:              rdata_mux = status_word;
      HSID_X_CTRL_LIBRARY_SIZE:        rdata_mux = library_size_q;
      HSID_X_CTRL_PIXEL_BANDS:         rdata_mux = pixel_bands_q;
      HSID_X_CTRL_CAPTURED_PIXEL_ADDR: rdata_mux = captured_pixel_addr_q;
      HSID_X_CTRL_LIBRARY_PIXEL_ADDR:  rdata_mux = library_pixel_addr_q;
      HSID_X_CTRL_MSE_MIN_REF:         rdata_mux = mse_min_ref_q;
      HSID_X_CTRL_MSE_MAX_REF:         rdata_mux = mse_max_ref_q;
      HSID_X_CTRL_MSE_MIN_VALUE:       rdata_mux = mse_min_value_q;
      HSID_X_CTRL_MSE_MAX_VALUE:       rdata_mux = mse_max_value_q;
      default:                         rdata_mux = '0;
    endcase
  end

  // Always-ready responder; data and error are held quiet while in reset.
  always_comb begin
    rsp       = '0;
    rsp.ready = 1'b1;
    if (!rst_i && reg_req_i.valid) begin
      rsp.error = !hit || (reg_req_i.write && !wr_legal);
      if (!reg_req_i.write && hit) rsp.rdata = rdata_mux;
    end
  end

  assign reg_rsp_o             = rsp;
  assign library_size_o        = library_size_q;
  assign pixel_bands_o         = pixel_bands_q;
  assign captured_pixel_addr_o = captured_pixel_addr_q;
  assign library_pixel_addr_o  = library_pixel_addr_q;

endmodule

// File: tb/tb_hsid_x_ctrl_reg_resp.sv
// Self-checking bench for hsid_x_ctrl_reg_resp: directed scenarios plus random traffic against a register-map model.
module tb_hsid_x_ctrl_reg_resp;
  import hsid_x_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  reg_req_t    req;
  reg_rsp_t    rsp;
  logic        hw_done;
  logic [15:0] min_ref, max_ref;
  logic [31:0] min_val, max_val;
  logic [31:0] lib_size, bands, cap_addr, lib_addr;
  logic        start, clear, irq;

  int n_checks = 0;
  int n_errors = 0;

  // Model: flat register image indexed by word offset, run state 0=idle 1=busy 2=done.
  logic [31:0] m_reg [0:8];
  int          m_state;
  bit          exp_start, exp_clear;

  always #5 clk = ~clk;

  hsid_x_ctrl_reg_resp dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .reg_req_i             (req),
    .reg_rsp_o             (rsp),
    .hw_done_i             (hw_done),
    .mse_min_ref_i         (min_ref),
    .mse_max_ref_i         (max_ref),
    .mse_min_value_i       (min_val),
    .mse_max_value_i       (max_val),
    .library_size_o        (lib_size),
    .pixel_bands_o         (bands),
    .captured_pixel_addr_o (cap_addr),
    .library_pixel_addr_o  (lib_addr),
    .start_o               (start),
    .clear_o               (clear),
    .irq_o                 (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_reg[i] = '0;
    m_state   = 0;
    exp_start = 0;
    exp_clear = 0;
  endtask

  task automatic check_outputs();
    check("start_o", 32'(start), 32'(exp_start));
    check("clear_o", 32'(clear), 32'(exp_clear));
    check("irq_o", 32'(irq), 32'(m_state == 2));
    check("library_size_o", lib_size, m_reg[1]);
    check("pixel_bands_o", bands, m_reg[2]);
    check("captured_pixel_addr_o", cap_addr, m_reg[3]);
    check("library_pixel_addr_o", lib_addr, m_reg[4]);
  endtask

  // One bus cycle: drive, check the combinational response, advance the model, clock, check outputs.
  task automatic xfer(input bit v, input bit w, input logic [5:0] a,
                      input logic [31:0] d, input logic [3:0] s, input bit done);
    logic [31:0] exp_rd;
    bit          exp_err, mapped, ok, st, cl;
    int          idx;
    logic [3:0]  permit;
    req.valid = v; req.write = w; req.addr = a; req.wdata = d; req.wstrb = s;
    hw_done   = done;
    #1;
    mapped = (a % 4 == 0) && (a <= 6'h20);
    idx    = int'(a) / 4;
    permit = (idx == 0) ? 4'b0001 : (idx <= 4 ? 4'b1111 : 4'b0000);
    exp_rd = 0; exp_err = 0; st = 0; cl = 0;
    if (v) begin
      if (!mapped) exp_err = 1;
      else if (!w) exp_rd = (idx == 0) ? (32'd4 << m_state) : m_reg[idx];
      else begin
        ok = (s != 0) && ((s & ~permit) == 0);
        if (ok && idx == 0 && d[0] && !d[1] && m_state == 1) ok = 0;
        exp_err = !ok;
        if (ok) begin
          if (idx == 0) begin
            st = d[0];
            cl = d[1];
          end else begin
            for (int b = 0; b < 4; b++)
              if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
          end
        end
      end
    end
    check("rsp.rdata", rsp.rdata, exp_rd);
    check("rsp.error", 32'(rsp.error), 32'(exp_err));
    check("rsp.ready", 32'(rsp.ready), 32'd1);
    exp_start = 0;
    exp_clear = 0;
    if (cl) begin
      m_state = 0;
      for (int i = 5; i < 9; i++) m_reg[i] = '0;
      exp_clear = 1;
    end else if (st && m_state != 1) begin
      m_state   = 1;
      exp_start = 1;
    end else if (m_state == 1 && done) begin
      m_state  = 2;
      m_reg[5] = {16'h0, min_ref};
      m_reg[6] = {16'h0, max_ref};
      m_reg[7] = min_val;
      m_reg[8] = max_val;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic rd(input logic [5:0] a);
    xfer(1, 0, a, 32'h0, 4'h0, 0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    xfer(1, 1, a, d, s, 0);
  endtask

  task automatic idle(input bit done);
    xfer(0, 0, 6'h0, 32'h0, 4'h0, done);
  endtask

  initial begin
    logic [5:0]  ra;
    logic [31:0] rdv;
    logic [3:0]  rs;
    int          r;

    req = '0; hw_done = 0;
    min_ref = 0; max_ref = 0; min_val = 0; max_val = 0;
    model_reset();

    // Reset: everything quiet, even an unmapped read reports no error.
    repeat (2) @(posedge clk);
    #1;
    req.valid = 1; req.addr = 6'h24;
    #1;
    check("reset_rsp_error", 32'(rsp.error), 32'd0);
    check("reset_rsp_rdata", rsp.rdata, 32'd0);
    check_outputs();
    @(posedge clk);
    #1;
    rst = 0;

    // Test 1: all registers read zero, STATUS reads IDLE.
    for (int i = 0; i <= 8; i++) rd(6'(i * 4));
    check("status_idle", {29'h0, 3'b100}, 32'd4 << m_state);

    // Test 2: config writes and readback.
    wr(6'h04, 32'h0000_0020, 4'hF);
    wr(6'h08, 32'h0000_00C8, 4'hF);
    rd(6'h04);
    rd(6'h08);
    check("library_size_0x20", lib_size, 32'h20);
    check("pixel_bands_0xC8", bands, 32'hC8);

    // Test 3: start, done, captured results.
    wr(6'h00, 32'h1, 4'h1);
    check("start_pulse_hi", 32'(start), 32'd1);
    idle(0);
    check("start_pulse_lo", 32'(start), 32'd0);
    rd(6'h00);
    min_ref = 16'd3; max_ref = 16'd7; min_val = 32'h10; max_val = 32'h900;
    idle(1);
    check("irq_after_done", 32'(irq), 32'd1);
    min_ref = 16'hFFFF; max_val = 32'hDEAD;
    idle(1);
    rd(6'h00);
    for (int i = 5; i <= 8; i++) rd(6'(i * 4));

    // Test 4: start while busy rejected, clear returns to idle.
    wr(6'h00, 32'h1, 4'h1);
    wr(6'h00, 32'h1, 4'h1);
    check("no_restart_pulse", 32'(start), 32'd0);
    wr(6'h00, 32'h2, 4'h1);
    check("clear_pulse", 32'(clear), 32'd1);
    rd(6'h00);
    for (int i = 5; i <= 8; i++) rd(6'(i * 4));
    check("irq_cleared", 32'(irq), 32'd0);

    // Test 5: illegal accesses.
    wr(6'h1C, 32'h1234_5678, 4'hF);
    wr(6'h00, 32'h1, 4'h3);
    wr(6'h04, 32'hFFFF_FFFF, 4'h0);
    rd(6'h24);
    rd(6'h02);
    rd(6'h00);

    // Test 6a: reset mid-busy drops the start pulse immediately.
    wr(6'h00, 32'h1, 4'h1);
    #1 rst = 1;
    #1;
    check("async_start_drop", 32'(start), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 0;
    rd(6'h00);

    // Test 6b: irq drops asynchronously; START+CLEAR in DONE is a clear only.
    wr(6'h00, 32'h1, 4'h1);
    min_ref = 16'h0042; max_ref = 16'h8001; min_val = 32'h5; max_val = 32'hABCD_0123;
    idle(1);
    wr(6'h00, 32'h3, 4'h1);
    check("start_clear_no_start", 32'(start), 32'd0);
    check("start_clear_clear", 32'(clear), 32'd1);
    rd(6'h00);
    wr(6'h00, 32'h1, 4'h1);
    idle(1);
    #1 rst = 1;
    #1;
    check("async_irq_drop", 32'(irq), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 10));
      ra = (r >= 9) ? 6'($urandom) : 6'(r * 4);
      rdv = $urandom;
      case ($urandom_range(0, 3))
        0: rs = 4'h1;
        1: rs = 4'hF;
        default: rs = 4'($urandom);
      endcase
      min_ref = 16'($urandom); max_ref = 16'($urandom);
      min_val = $urandom;      max_val = $urandom;
      xfer(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), ra, rdv, rs,
           $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hsid_x_ctrl_reg_resp.md
Name: hsid_x_ctrl_reg_resp

Overview:
- Responder (device) end of the HSID-X control register interface, driven by `reg_req_t` from the bus or bench; answers with `reg_rsp_t`.
- Holds the configuration registers: library size, pixel bands, captured/library pixel addresses.
- Holds a STATUS register backed by a run FSM (IDLE/BUSY/DONE) and captures the MSE result registers from the hsid_x core on completion.
- Sits between the bus and the hsid_x core; drives start/clear pulses and the completion interrupt.

Parameters:
- WORD_WIDTH, HSID_WORD_WIDTH (32), data and register width.
- ADDR_WIDTH, BlockAw (6), decoded address bits.
- REF_WIDTH, 16, width of the MSE min/max reference index fields.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- reg_req_i  in  reg_req_t  valid, write, addr, wdata, wstrb
- reg_rsp_o  out  reg_rsp_t  rdata, error, ready
- hw_done_i  in  1  core finished one library sweep (1-cycle pulse)
- mse_min_ref_i  in  REF_WIDTH  library index of minimum MSE
- mse_max_ref_i  in  REF_WIDTH  library index of maximum MSE
- mse_min_value_i  in  WORD_WIDTH  minimum MSE value
- mse_max_value_i  in  WORD_WIDTH  maximum MSE value
- library_size_o  out  WORD_WIDTH  configured library size
- pixel_bands_o  out  WORD_WIDTH  configured bands per pixel
- captured_pixel_addr_o  out  WORD_WIDTH  captured pixel base address
- library_pixel_addr_o  out  WORD_WIDTH  library base address
- start_o  out  1  1-cycle start pulse to core
- clear_o  out  1  1-cycle clear pulse to core
- irq_o  out  1  level interrupt, high in DONE

Behaviour:
- Reset (async, rst_i=1): all config registers 0; MSE captures 0; FSM=IDLE; start_o, clear_o and irq_o are 0; reg_rsp_o.rdata and .error are 0.
- Handshake: reg_rsp_o.ready=1 always. A transfer completes in every cycle with valid=1. rdata and error are combinational from the current request and register state. Register updates take effect on the next rising edge.
- Address map (byte offsets, addr[ADDR_WIDTH-1:0]):
  - STATUS 0x00
  - LIBRARY_SIZE 0x04
  - PIXEL_BANDS 0x08
  - CAPTURED_PIXEL_ADDR 0x0C
  - LIBRARY_PIXEL_ADDR 0x10
  - MSE_MIN_REF 0x14
  - MSE_MAX_REF 0x18
  - MSE_MIN_VALUE 0x1C
  - MSE_MAX_VALUE 0x20
- Unmapped or non-word-aligned address: rdata=0, error=1, no state change.
- Write permission: each register has a permitted strobe mask, HSID_X_CTRL_PERMIT[id].
  - Config registers: 4'b1111.
  - STATUS: 4'b0001.
  - MSE registers: 4'b0000 (read-only).
- A write with wstrb=0, or with any wstrb bit outside the permit mask: error=1, nothing written.
- Legal writes update only the strobed bytes.
- STATUS read layout: bit0 START=0, bit1 CLEAR=0, bit2 IDLE, bit3 BUSY, bit4 DONE, rest 0. Exactly one of IDLE/BUSY/DONE is set.
- FSM transitions:
  - IDLE, write START=1 → BUSY; start_o=1 for the following cycle.
  - BUSY, hw_done_i=1 → DONE; capture the four MSE inputs (refs zero-extended) on that edge; irq_o=1 from the next cycle.
  - DONE, write START=1 → BUSY with a new start_o pulse; captures are kept until the next hw_done_i.
  - Any state, write CLEAR=1 → IDLE; clear_o pulse; MSE captures zeroed.
  - CLEAR wins if START and CLEAR are written together.
  - BUSY, write START=1 → error=1, ignored, no pulse.
  - hw_done_i while IDLE or DONE → ignored.
- Config writes while BUSY: accepted (no error). Outputs update immediately. The core samples them only at start_o.
- A read has no side effects; reading DONE does not clear it.
- Reset asserted mid-BUSY: immediate return to IDLE. Pulses and irq_o drop asynchronously.

Decomposition:
- hsid_x_ctrl_reg_pkg: hsid_x_ctrl_id_e, the *_OFFSET constants, HSID_X_CTRL_PERMIT, STATUS bit-index constants, FSM enum hsid_x_ctrl_state_e.
- reg_req_t / reg_rsp_t come from hsid_x_reg_pkg.
- One natural sub-module: hsid_x_ctrl_fsm (state register, start/clear pulses, irq_o, capture enable). The decode and register file stay in the top.

Test Plan:
1. Reset, then read every register → rdata=0, error=0; STATUS=0x04 (IDLE).
2. Write LIBRARY_SIZE=0x00000020, PIXEL_BANDS=0x000000C8, wstrb 4'b1111 → read back 0x20 and 0xC8; library_size_o=0x20; pixel_bands_o=0xC8.
3. Write STATUS=0x1 → start_o high exactly 1 cycle; STATUS=0x08. Pulse hw_done_i with min_ref=3, max_ref=7, min_value=0x10, max_value=0x900 → irq_o=1; STATUS=0x10; the MSE registers read 3, 7, 0x10, 0x900.
4. In BUSY write STATUS=0x1 → error=1, no start_o. Write STATUS=0x2 → clear_o pulse; STATUS=0x04; MSE registers read 0; irq_o=0.
5. Write MSE_MIN_VALUE, write STATUS with wstrb 4'b0011, and read addr 0x24 and 0x02 → error=1 each, no state change.
6. Assert rst_i mid-BUSY, and write START+CLEAR (0x3) in DONE → IDLE immediately in both cases; the 0x3 write gives clear_o only, no start_o.
